// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin ROB write-back arbiter with flush-aware one-entry slots
// Optional perf counters are built when WB_ARB_PERF_EN is defined.
module wb_arbiter #(
   parameter int N_REQ  = 3,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 3,
   parameter int PRD_W  = 7
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [N_REQ*DATA_W-1:0]  req_data,
   input  logic [N_REQ*IDX_W-1:0]   req_rob_idx,
   input  logic [N_REQ*PRD_W-1:0]   req_P_rd,
   output logic [N_REQ-1:0]         req_ready,
   input  logic                     mispredict,
   input  logic [2**IDX_W-1:0]      flush_mask,
   output logic                     WB_valid,
   output logic [DATA_W-1:0]        WB_data,
   output logic [IDX_W-1:0]         WB_rob_idx,
   output logic [PRD_W-1:0]         WB_P_rd,
   output logic [N_REQ-1:0]         WB_grant
`ifdef WB_ARB_PERF_EN
  ,output logic [31:0]              perf_conflict_cnt,
   output logic [31:0]              perf_flush_drop_cnt
`endif
);
   localparam int PTR_W = (N_REQ > 2) ? 2 : 1;

   logic [N_REQ-1:0]  slot_valid;
   logic [DATA_W-1:0] slot_data [N_REQ];
   logic [IDX_W-1:0]  slot_idx  [N_REQ];
   logic [PRD_W-1:0]  slot_prd  [N_REQ];
   logic [PTR_W-1:0]  rr_ptr;
   logic [PTR_W-1:0]  gnt_idx;
   logic [N_REQ-1:0]  slot_flush, in_flush, cand, gnt, take;
   logic              found;

   always_comb begin
      slot_flush = '0;
      in_flush   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         slot_flush[i] = slot_valid[i] && mispredict && flush_mask[slot_idx[i]];
         in_flush[i]   = mispredict && flush_mask[req_rob_idx[i*IDX_W +: IDX_W]];
      end
   end

   assign cand      = slot_valid & ~slot_flush;
   assign req_ready = ~slot_valid | gnt | slot_flush;
   assign take      = req_valid & req_ready & ~in_flush;

   // Two passes give the rotated priority: indices at/after rr_ptr first, then the wrap.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++)
         if (!found && cand[i] && i >= int'(rr_ptr)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = PTR_W'(i);
         end
      for (int i = 0; i < N_REQ; i++)
         if (!found && cand[i] && i < int'(rr_ptr)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = PTR_W'(i);
         end
   end

   always_comb begin
      WB_data    = '0;
      WB_rob_idx = '0;
      WB_P_rd    = '0;
      for (int i = 0; i < N_REQ; i++)
         if (gnt[i]) begin
            WB_data    = WB_data    | slot_data[i];
            WB_rob_idx = WB_rob_idx | slot_idx[i];
            WB_P_rd    = WB_P_rd    | slot_prd[i];
         end
   end

   assign WB_valid = |gnt;
   assign WB_grant = gnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_valid <= '0;
         rr_ptr     <= '0;
         for (int i = 0; i < N_REQ; i++) begin
            slot_data[i] <= '0;
            slot_idx[i]  <= '0;
            slot_prd[i]  <= '0;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            // A fresh capture wins over release or flush of the old contents.
            if (take[i]) begin
               slot_valid[i] <= 1'b1;
               slot_data[i]  <= req_data[i*DATA_W +: DATA_W];
               slot_idx[i]   <= req_rob_idx[i*IDX_W +: IDX_W];
               slot_prd[i]   <= req_P_rd[i*PRD_W +: PRD_W];
            end else if (gnt[i] || slot_flush[i]) begin
               slot_valid[i] <= 1'b0;
            end
         end
         if (found)
            rr_ptr <= (gnt_idx == PTR_W'(N_REQ-1)) ? '0 : gnt_idx + PTR_W'(1);
      end
   end

`ifdef WB_ARB_PERF_EN
   logic [31:0] n_cand, n_drop;

   always_comb begin
      n_cand = '0;
      n_drop = '0;
      for (int i = 0; i < N_REQ; i++) begin
         n_cand = n_cand + 32'(cand[i]);
         n_drop = n_drop + 32'(slot_flush[i]) + 32'(req_valid[i] && req_ready[i] && in_flush[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         perf_conflict_cnt   <= '0;
         perf_flush_drop_cnt <= '0;
      end else begin
         if (n_cand >= 32'd2)
            perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
         perf_flush_drop_cnt <= perf_flush_drop_cnt + n_drop;
      end
   end
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - directed and randomized checks of wb_arbiter against a behavioural model
module tb_wb_arbiter;
   localparam int N = 3;
   localparam int DW = 32;
   localparam int IW = 3;
   localparam int PW = 7;

   logic          clk;
   logic          rst;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N*IW-1:0] req_rob_idx;
   logic [N*PW-1:0] req_P_rd;
   logic [N-1:0]  req_ready;
   logic          mispredict;
   logic [7:0]    flush_mask;
   logic          WB_valid;
   logic [DW-1:0] WB_data;
   logic [IW-1:0] WB_rob_idx;
   logic [PW-1:0] WB_P_rd;
   logic [N-1:0]  WB_grant;
`ifdef WB_ARB_PERF_EN
   logic [31:0]   perf_conflict_cnt;
   logic [31:0]   perf_flush_drop_cnt;
`endif

   int checks = 0;
   int failures = 0;

   wb_arbiter #(.N_REQ(N), .DATA_W(DW), .IDX_W(IW), .PRD_W(PW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_rob_idx(req_rob_idx), .req_P_rd(req_P_rd),
      .req_ready(req_ready), .mispredict(mispredict), .flush_mask(flush_mask),
      .WB_valid(WB_valid), .WB_data(WB_data), .WB_rob_idx(WB_rob_idx), .WB_P_rd(WB_P_rd),
      .WB_grant(WB_grant)
`ifdef WB_ARB_PERF_EN
     ,.perf_conflict_cnt(perf_conflict_cnt), .perf_flush_drop_cnt(perf_flush_drop_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: each requester holds at most one result; the pointer names
   // the requester with highest priority, and the winner is the first holder found
   // walking forward from it.
   bit        m_v [N];
   int        m_d [N];
   int        m_i [N];
   int        m_p [N];
   int        m_rr;
   bit [N-1:0] e_grant, e_ready;
   bit        e_valid;
   int        e_data, e_idx, e_prd;

   function automatic bit squashed(int idx);
      return mispredict && flush_mask[idx];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_v[i] = 0; m_d[i] = 0; m_i[i] = 0; m_p[i] = 0;
      end
      m_rr = 0;
   endtask

   task automatic model_eval();
      int j;
      e_grant = '0; e_valid = 0; e_data = 0; e_idx = 0; e_prd = 0;
      for (int k = 0; k < N; k++) begin
         j = (m_rr + k) % N;
         if (!e_valid && m_v[j] && !squashed(m_i[j])) begin
            e_valid = 1; e_grant[j] = 1'b1;
            e_data = m_d[j]; e_idx = m_i[j]; e_prd = m_p[j];
         end
      end
      for (int i = 0; i < N; i++)
         e_ready[i] = !m_v[i] || e_grant[i] || (m_v[i] && squashed(m_i[i]));
   endtask

   task automatic model_clock();
      int g;
      g = -1;
      for (int i = 0; i < N; i++) if (e_grant[i]) g = i;
      for (int i = 0; i < N; i++) begin
         if (req_valid[i] && e_ready[i] && !squashed(int'(req_rob_idx[i*IW +: IW]))) begin
            m_v[i] = 1;
            m_d[i] = int'(req_data[i*DW +: DW]);
            m_i[i] = int'(req_rob_idx[i*IW +: IW]);
            m_p[i] = int'(req_P_rd[i*PW +: PW]);
         end else if (e_grant[i] || (m_v[i] && squashed(m_i[i]))) begin
            m_v[i] = 0;
         end
      end
      if (g >= 0) m_rr = (g + 1) % N;
   endtask

   task automatic clear_inputs();
      req_valid = '0; req_data = '0; req_rob_idx = '0; req_P_rd = '0;
      mispredict = 1'b0; flush_mask = '0;
   endtask

   task automatic drive(int i, int idx, logic [31:0] data, int prd);
      req_valid[i] = 1'b1;
      req_rob_idx[i*IW +: IW] = IW'(idx);
      req_data[i*DW +: DW] = data;
      req_P_rd[i*PW +: PW] = PW'(prd);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      model_reset();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_reset();
      clear_inputs();
      rst = 1'b1;
      #2;
      checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL reset_wb_valid: got %b expected 0", WB_valid); end
      checks++; if (WB_grant !== 3'b000) begin failures++; $display("FAIL reset_grant: got %b expected 000", WB_grant); end
      checks++; if (WB_data !== 32'd0 || WB_rob_idx !== 3'd0 || WB_P_rd !== 7'd0) begin failures++; $display("FAIL reset_wb_fields: got %h/%h/%h expected 0/0/0", WB_data, WB_rob_idx, WB_P_rd); end
      checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL reset_ready: got %b expected 111", req_ready); end
      model_reset();
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic test_single();
      do_reset();
      drive(0, 2, 32'hDEAD_BEEF, 9);
      @(negedge clk);
      checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL single_no_bypass: got %b expected 0", WB_valid); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++; if (WB_valid !== 1'b1 || WB_grant !== 3'b001) begin failures++; $display("FAIL single_grant: got %b/%b expected 1/001", WB_valid, WB_grant); end
      checks++; if (WB_data !== 32'hDEAD_BEEF || WB_rob_idx !== 3'd2 || WB_P_rd !== 7'd9) begin failures++; $display("FAIL single_fields: got %h/%0d/%0d expected deadbeef/2/9", WB_data, WB_rob_idx, WB_P_rd); end
      next_cycle();
      @(negedge clk);
      checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL single_release: got %b expected 0", WB_valid); end
   endtask

   task automatic test_contention();
      do_reset();
      for (int i = 0; i < N; i++) drive(i, i, 32'hA0 + i, 10 + i);
      next_cycle();
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checks++; if (WB_grant !== 3'(1 << (k % 3))) begin failures++; $display("FAIL contention_grant_%0d: got %b expected %b", k, WB_grant, 3'(1 << (k % 3))); end
         checks++; if (WB_data !== 32'hA0 + (k % 3)) begin failures++; $display("FAIL contention_data_%0d: got %h expected %h", k, WB_data, 32'hA0 + (k % 3)); end
         next_cycle();
      end
      clear_inputs();
      @(negedge clk);
      checks++; if (WB_grant !== 3'b001) begin failures++; $display("FAIL contention_wrap: got %b expected 001", WB_grant); end
   endtask

   task automatic test_back_to_back();
      do_reset();
      for (int k = 0; k < 6; k++) begin
         clear_inputs();
         drive(1, k, 32'h111 * k, k + 1);
         @(negedge clk);
         checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d: got %b expected 1", k, req_ready[1]); end
         if (k > 0) begin
            checks++; if (WB_valid !== 1'b1 || WB_rob_idx !== 3'(k - 1)) begin failures++; $display("FAIL b2b_wb_%0d: got %b/%0d expected 1/%0d", k, WB_valid, WB_rob_idx, k - 1); end
         end
         next_cycle();
      end
      clear_inputs();
   endtask

   task automatic test_flush_slot();
      do_reset();
      drive(0, 3, 32'h3333, 3);
      drive(1, 5, 32'h5555, 5);
      next_cycle();
      clear_inputs();
      mispredict = 1'b1;
      flush_mask = 8'b0010_0000;
      @(negedge clk);
      checks++; if (WB_grant !== 3'b001 || WB_rob_idx !== 3'd3) begin failures++; $display("FAIL flush_slot_grant: got %b/%0d expected 001/3", WB_grant, WB_rob_idx); end
      checks++; if (req_ready[1] !== 1'b1) begin failures++; $display("FAIL flush_slot_ready: got %b expected 1", req_ready[1]); end
      next_cycle();
      clear_inputs();
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL flush_slot_leak_%0d: got valid %b idx %0d expected 0", k, WB_valid, WB_rob_idx); end
         next_cycle();
      end
   endtask

   task automatic test_flush_incoming();
`ifdef WB_ARB_PERF_EN
      logic [31:0] before;
`endif
      do_reset();
`ifdef WB_ARB_PERF_EN
      before = perf_flush_drop_cnt;
`endif
      drive(2, 6, 32'h6666, 6);
      mispredict = 1'b1;
      flush_mask = 8'b0100_0000;
      @(negedge clk);
      checks++; if (req_ready[2] !== 1'b1) begin failures++; $display("FAIL flush_in_ready: got %b expected 1", req_ready[2]); end
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL flush_in_captured: got %b expected 0", WB_valid); end
`ifdef WB_ARB_PERF_EN
      checks++; if (perf_flush_drop_cnt !== before + 32'd1) begin failures++; $display("FAIL flush_in_perf: got %0d expected %0d", perf_flush_drop_cnt, before + 32'd1); end
`endif
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < N; i++) drive(i, i, 32'hC0 + i, i + 1);
      next_cycle();
      clear_inputs();
      next_cycle();
      #2 rst = 1'b1;
      #1;
      checks++; if (WB_valid !== 1'b0) begin failures++; $display("FAIL midrst_valid: got %b expected 0", WB_valid); end
      checks++; if (req_ready !== 3'b111) begin failures++; $display("FAIL midrst_ready: got %b expected 111", req_ready); end
      next_cycle();
      rst = 1'b0;
      model_reset();
      drive(0, 4, 32'hF0, 4);
      drive(1, 2, 32'hF1, 2);
      next_cycle();
      clear_inputs();
      @(negedge clk);
      checks++; if (WB_grant !== 3'b001 || WB_rob_idx !== 3'd4) begin failures++; $display("FAIL midrst_first_grant: got %b/%0d expected 001/4", WB_grant, WB_rob_idx); end
   endtask

   task automatic test_random();
      bit used [8];
      int idx, start;
      do_reset();
      for (int cyc = 0; cyc < 400; cyc++) begin
         clear_inputs();
         for (int t = 0; t < 8; t++) used[t] = 0;
         for (int i = 0; i < N; i++) if (m_v[i]) used[m_i[i]] = 1;
         for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 99) < 55) begin
               start = $urandom_range(0, 7);
               idx = -1;
               for (int t = 0; t < 8; t++)
                  if (idx < 0 && !used[(start + t) % 8]) idx = (start + t) % 8;
               used[idx] = 1;
               drive(i, idx, $urandom, $urandom_range(0, 127));
            end
         end
         if ($urandom_range(0, 99) < 20) begin
            mispredict = 1'b1;
            flush_mask = 8'($urandom);
         end
         @(negedge clk);
         model_eval();
         checks++; if (WB_valid !== e_valid) begin failures++; $display("FAIL rand_valid@%0d: got %b expected %b", cyc, WB_valid, e_valid); end
         checks++; if (WB_grant !== e_grant) begin failures++; $display("FAIL rand_grant@%0d: got %b expected %b", cyc, WB_grant, e_grant); end
         checks++; if (WB_data !== 32'(e_data) || WB_rob_idx !== 3'(e_idx) || WB_P_rd !== 7'(e_prd)) begin failures++; $display("FAIL rand_fields@%0d: got %h/%0d/%0d expected %h/%0d/%0d", cyc, WB_data, WB_rob_idx, WB_P_rd, e_data, e_idx, e_prd); end
         checks++; if (req_ready !== e_ready) begin failures++; $display("FAIL rand_ready@%0d: got %b expected %b", cyc, req_ready, e_ready); end
         checks++; if (!$onehot0(WB_grant) || WB_valid !== (|WB_grant)) begin failures++; $display("FAIL rand_onehot@%0d: got grant %b valid %b expected onehot0 and consistent", cyc, WB_grant, WB_valid); end
         model_clock();
         next_cycle();
      end
      clear_inputs();
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single();
      test_contention();
      test_back_to_back();
      test_flush_slot();
      test_flush_incoming();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
